// File: rtl/pc_module.sv
// ----------------------------------------------------------------------------
// pc_module
// Program counter for the CPU fetch stage, with a link register (R15).
// Each rising edge the PC either steps to the next sequential address or
// loads an absolute jump target. A taken jump also stores the return
// address (old PC + STEP) in R15.
//
// Ports:
//   clk        in   system clock; all state updates on the rising edge
//   rst        in   synchronous reset, active-high; has priority over sel
//   sel        in   0 = sequential (PC + STEP), 1 = jump to jump_to
//   jump_to    in   absolute jump target, sampled at the rising edge
//   R15_value  out  link register: return address of the most recent jump
//   PC_out     out  current program counter
// ----------------------------------------------------------------------------
module pc_module #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned RESET_VECTOR = 0,
    parameter int unsigned STEP         = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sel,
    input  logic [WIDTH-1:0] jump_to,
    output logic [WIDTH-1:0] R15_value,
    output logic [WIDTH-1:0] PC_out
);

    localparam logic [WIDTH-1:0] LP_RESET_PC = WIDTH'(RESET_VECTOR);
    localparam logic [WIDTH-1:0] LP_STEP     = WIDTH'(STEP);

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_r15;
    logic [WIDTH-1:0] w_pc_seq;

    // Sequential address; truncation to WIDTH gives the modulo wrap that is
    // shared by the PC increment and the return-address capture.
    assign w_pc_seq = r_pc + LP_STEP;

    // PC and link register update
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc  <= LP_RESET_PC;
            r_r15 <= '0;
        end else if (sel) begin
            r_pc  <= jump_to;
            r_r15 <= w_pc_seq;
        end else begin
            r_pc  <= w_pc_seq;
        end
    end

    assign PC_out    = r_pc;
    assign R15_value = r_r15;

endmodule

// File: tb/tb_pc_module.sv
// ----------------------------------------------------------------------------
// tb_pc_module
// Self-checking bench for pc_module: directed scenarios with literal
// expectations, then randomized traffic, all compared every cycle against a
// behavioural model of the program counter and link register.
// ----------------------------------------------------------------------------
module tb_pc_module;

    logic       clk;
    logic       rst;
    logic       sel;
    logic [7:0] jump_to;
    logic [7:0] R15_value;
    logic [7:0] PC_out;

    int total = 0;
    int bad   = 0;

    // Behavioural model state (plain integers, modulo 256)
    int m_pc    = 0;
    int m_r15   = 0;
    bit m_valid = 1'b0;

    pc_module #(
        .WIDTH       (8),
        .RESET_VECTOR(0),
        .STEP        (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sel      (sel),
        .jump_to  (jump_to),
        .R15_value(R15_value),
        .PC_out   (PC_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: reset wins, a jump saves old PC + 1 and loads the target,
    // otherwise the PC counts up with 8-bit wrap.
    always @(posedge clk) begin
        if (rst) begin
            m_pc    = 0;
            m_r15   = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            if (sel) begin
                m_r15 = (m_pc + 1) % 256;
                m_pc  = int'(jump_to);
            end else begin
                m_pc = (m_pc + 1) % 256;
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge
    always @(negedge clk) begin
        if (m_valid) begin
            check("model_pc", int'(PC_out), m_pc);
            check("model_r15", int'(R15_value), m_r15);
        end
    end

    // Apply inputs for one edge and return just after that edge
    task automatic drive(input logic r, input logic s, input logic [7:0] j);
        rst     = r;
        sel     = s;
        jump_to = j;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst     = 1'b1;
        sel     = 1'b0;
        jump_to = 8'h00;

        // Reset then run
        drive(1'b1, 1'b0, 8'h00);
        check("reset_pc", int'(PC_out), 0);
        check("reset_r15", int'(R15_value), 0);
        for (int i = 1; i <= 5; i++) begin
            drive(1'b0, 1'b0, 8'($urandom));
            check("run_pc", int'(PC_out), i);
            check("run_r15", int'(R15_value), 0);
        end

        // Single jump from PC=5
        drive(1'b0, 1'b1, 8'h40);
        check("jump_pc", int'(PC_out), 'h40);
        check("jump_r15", int'(R15_value), 6);
        drive(1'b0, 1'b0, 8'h00);
        check("after_jump_pc", int'(PC_out), 'h41);
        check("after_jump_r15", int'(R15_value), 6);

        // PC wrap; R15 untouched by sequential steps
        drive(1'b0, 1'b1, 8'hFE);
        check("wrap_jump_pc", int'(PC_out), 'hFE);
        check("wrap_jump_r15", int'(R15_value), 'h42);
        drive(1'b0, 1'b0, 8'h00);
        check("wrap_pc_ff", int'(PC_out), 'hFF);
        drive(1'b0, 1'b0, 8'h00);
        check("wrap_pc_00", int'(PC_out), 'h00);
        drive(1'b0, 1'b0, 8'h00);
        check("wrap_pc_01", int'(PC_out), 'h01);
        check("wrap_r15", int'(R15_value), 'h42);

        // Return-address wrap from PC=0xFF
        drive(1'b0, 1'b1, 8'hFF);
        check("pre_ret_pc", int'(PC_out), 'hFF);
        check("pre_ret_r15", int'(R15_value), 'h02);
        drive(1'b0, 1'b1, 8'h10);
        check("ret_wrap_pc", int'(PC_out), 'h10);
        check("ret_wrap_r15", int'(R15_value), 'h00);

        // Jump to the current PC
        drive(1'b0, 1'b1, 8'h10);
        check("self_jump_pc", int'(PC_out), 'h10);
        check("self_jump_r15", int'(R15_value), 'h11);

        // Alternating select, jump_to advancing by 5 each window
        for (int w = 0; w < 8; w++) begin
            for (int c = 0; c < 5; c++) begin
                drive(1'b0, 1'(w % 2), 8'(w * 5));
            end
        end

        // Reset priority over a simultaneous jump
        drive(1'b1, 1'b1, 8'h77);
        check("rst_prio_pc", int'(PC_out), 0);
        check("rst_prio_r15", int'(R15_value), 0);
        drive(1'b0, 1'b0, 8'h00);
        check("rst_prio_next_pc", int'(PC_out), 1);

        // Randomized traffic with occasional mid-sequence resets
        for (int n = 0; n < 3000; n++) begin
            drive(1'(($urandom % 40) == 0), 1'($urandom % 2), 8'($urandom));
        end

        drive(1'b0, 1'b0, 8'h00);
        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
